tt_um_serial_subtractor_yoda: RTL and testbench

Bit-serial 6-bit subtractor tile for the Tiny Tapeout harness, the sequential counterpart to the team's combinational full-adder tile. It computes D = A − B − Bin one bit per clock through a single full-subtractor cell with a registered borrow. It sits directly behind the standard TT pin wrapper. Operands and control arrive on `ui_in`/`uio_in`; the difference, borrow-out and status leave on `uo_out`/`uio_out`.

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/full_subtractor_cell.sv | 14 +
 rtl/tt_um_serial_subtractor_yoda.sv | 118 +++++++++++
 tb/tb_tt_um_serial_subtractor_yoda.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared constants and types for the bit-serial subtractor tile.
package serial_sub_pkg;

  localparam int WIDTH = 6;
  localparam int CNT_W = 3;

  // Counter value on the edge that processes the MSB.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Only the two debug/status bits of the bidirectional bus are driven.
  localparam logic [7:0] UIO_OE = 8'b1100_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow when b exceeds a, or when a equals b and a borrow arrives.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_serial_subtractor_yoda.sv
// Bit-serial 6-bit subtractor D = A - B - Bin, LSB first, one bit per clock.
module tt_um_serial_subtractor_yoda
  import serial_sub_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  // Input field decode.
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             start;
  logic             bin;

  assign a_in  = ui_in[WIDTH-1:0];
  assign start = ui_in[6];
  assign bin   = ui_in[7];
  assign b_in  = uio_in[WIDTH-1:0];

  wire unused = &{1'b0, ena, uio_in[7:6]};

  // Datapath and control state.
  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d_res;
  logic             bout_res;
  logic             busy;
  logic             done;

  logic cell_d;
  logic cell_bout;

  full_subtractor_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // FSM, shift registers, borrow flop and result registers.
  // NOTE: every register here, including the result, is asynchronously
  // cleared so a reset mid-operation leaves the outputs reading zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      d_res    <= '0;
      bout_res <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch reads the pre-edge
      // values of the shift registers and borrow.
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= {cell_d, d_sr[WIDTH-1:1]};
          br   <= cell_bout;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            d_res    <= {cell_d, d_sr[WIDTH-1:1]};
            bout_res <= cell_bout;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          // Holding start keeps us here so one pulse launches one operation.
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Output packing; the serial debug bit is gated so it reads 0 outside SHIFT.
  assign uo_out  = {done, bout_res, d_res};
  assign uio_out = {cell_d & (state == SHIFT), busy, 6'b0};
  assign uio_oe  = UIO_OE;

endmodule

// File: tb/tb_tt_um_serial_subtractor_yoda.sv
// Directed self-checking bench for the bit-serial subtractor tile.
module tb_tt_um_serial_subtractor_yoda;

  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int vectors;
  int miscompares;

  // Last completed result as {Bout, D}; outputs must hold it while busy.
  logic [6:0] last_res;

  tt_um_serial_subtractor_yoda dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Launch one operation at the next edge and wait for done.
  // Returns the number of busy cycles and edges from start-sample to done.
  task automatic run_op(input string tag, input logic [5:0] a,
                        input logic [5:0] b, input logic bi,
                        input logic hold_start);
    int busy_cycles;
    int lat;
    bit seen_done;
    @(negedge clk);
    ui_in  = {bi, 1'b1, a};
    uio_in = {2'b11, b};
    @(negedge clk);                 // E0 has sampled start
    if (!hold_start) ui_in[6] = 1'b0;
    busy_cycles = 0;
    lat         = 0;
    seen_done   = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (uo_out[7]) begin
        seen_done = 1'b1;
        break;
      end
      if (uio_out[6]) busy_cycles++;
      check({tag, "_hold_prev"}, {25'd0, uo_out[6:0]}, {25'd0, last_res});
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, {31'd0, seen_done}, 32'd1);
    check({tag, "_latency"}, lat, 6);
    check({tag, "_busy_cycles"}, busy_cycles, 6);
    check({tag, "_busy_at_done"}, {31'd0, uio_out[6]}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [5:0] exp_d,
                              input logic exp_bout);
    check({tag, "_d"}, {26'd0, uo_out[5:0]}, {26'd0, exp_d});
    check({tag, "_bout"}, {31'd0, uo_out[6]}, {31'd0, exp_bout});
    last_res = {exp_bout, exp_d};
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_res    = 7'd0;
    ena         = 1'b1;
    ui_in       = 8'd0;
    uio_in      = 8'd0;
    rst_n       = 1'b0;

    // Reset state.
    #12;
    check("rst_uo_out", {24'd0, uo_out}, 32'h00);
    check("rst_uio_out", {24'd0, uio_out}, 32'h00);
    check("rst_uio_oe", {24'd0, uio_oe}, 32'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 5 - 3 = 2, then done drops one edge after start is released.
    run_op("op_5m3", 6'd5, 6'd3, 1'b0, 1'b0);
    check_result("op_5m3", 6'd2, 1'b0);
    @(negedge clk);
    check("op_5m3_done_fall", {31'd0, uo_out[7]}, 32'd0);
    check("op_5m3_d_kept", {26'd0, uo_out[5:0]}, 32'd2);

    // 3 - 5 wraps to 62 with borrow.
    run_op("op_3m5", 6'd3, 6'd5, 1'b0, 1'b0);
    check_result("op_3m5", 6'd62, 1'b1);

    // 0 - 0 - 1 = 63 with borrow; then 63 - 63 = 0, old result holds meanwhile.
    run_op("op_0m0b", 6'd0, 6'd0, 1'b1, 1'b0);
    check_result("op_0m0b", 6'd63, 1'b1);
    run_op("op_63m63", 6'd63, 6'd63, 1'b0, 1'b0);
    check_result("op_63m63", 6'd0, 1'b0);

    // Start held through completion: done sticks, nothing relaunches.
    run_op("op_hold", 6'd7, 6'd2, 1'b0, 1'b1);
    check_result("op_hold", 6'd5, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_done_stays", {31'd0, uo_out[7]}, 32'd1);
    check("hold_no_relaunch", {31'd0, uio_out[6]}, 32'd0);
    ui_in[6] = 1'b0;
    @(negedge clk);
    check("hold_done_fall", {31'd0, uo_out[7]}, 32'd0);

    // Re-armed operation: 20 - 1 - 1 = 18.
    run_op("op_rearm", 6'd20, 6'd1, 1'b1, 1'b0);
    check_result("op_rearm", 6'd18, 1'b0);

    // Operand changes and a start pulse during SHIFT are ignored.
    @(negedge clk);
    ui_in  = {1'b0, 1'b1, 6'd10};
    uio_in = {2'b00, 6'd4};
    @(negedge clk);                 // E0
    ui_in  = {1'b1, 1'b0, 6'd63};
    uio_in = {2'b00, 6'd63};
    @(negedge clk);
    ui_in[6] = 1'b1;
    @(negedge clk);
    ui_in[6] = 1'b0;
    repeat (4) @(negedge clk);      // after E6
    check("shiftchg_done", {31'd0, uo_out[7]}, 32'd1);
    check_result("shiftchg", 6'd6, 1'b0);
    repeat (4) @(negedge clk);
    check("shiftchg_no_extra_busy", {31'd0, uio_out[6]}, 32'd0);
    check("shiftchg_no_extra_done", {31'd0, uo_out[7]}, 32'd0);
    check("shiftchg_d_kept", {26'd0, uo_out[5:0]}, 32'd6);

    // Reset asserted while bit 3 is being processed clears everything at once.
    ui_in  = {1'b0, 1'b1, 6'd9};
    uio_in = {2'b00, 6'd1};
    @(negedge clk);                 // E0
    ui_in[6] = 1'b0;
    repeat (3) @(negedge clk);      // after E3, bit 3 pending
    check("mid_busy_before_rst", {31'd0, uio_out[6]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uo_out", {24'd0, uo_out}, 32'h00);
    check("mid_rst_uio_out", {24'd0, uio_out}, 32'h00);
    last_res = 7'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {24'd0, uio_out}, 32'h00);

    // Normal operation after reset: 33 - 40 = 57 with borrow.
    run_op("op_post_rst", 6'd33, 6'd40, 1'b0, 1'b0);
    check_result("op_post_rst", 6'd57, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
